// File: rtl/store_rmw_unit_pkg.sv
// store_rmw_unit_pkg: store type encodings and FSM state encoding for the store RMW unit
package store_rmw_unit_pkg;
   localparam logic [2:0] ST_SW   = 3'b000;
   localparam logic [2:0] ST_SB   = 3'b001;
   localparam logic [2:0] ST_SH   = 3'b010;
   localparam logic [2:0] ST_SWRR = 3'b100;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
endpackage

// File: rtl/store_merge.sv
// store_merge: merges store data into the old memory word (sb/sh) or rotates it (swrr)
module store_merge
   import store_rmw_unit_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [2:0]  sel,
   input  logic [1:0]  k,
   output logic [31:0] merged
);
   logic [31:0] rot;
   assign rot = k == 2'd0 ? wdata :
                k == 2'd1 ? {wdata[23:0], wdata[31:24]} :
                k == 2'd2 ? {wdata[15:0], wdata[31:16]} :
                            {wdata[7:0], wdata[31:8]};
   always_comb begin
      merged = sel == ST_SWRR ? rot : wdata;
      if (sel == ST_SB) begin
         merged = old_word;
         merged[8*k +: 8] = wdata[7:0];
      end
      if (sel == ST_SH) begin
         merged = old_word;
         merged[16*k[1] +: 16] = wdata[15:0];
      end
   end
endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sub-word store via read-modify-write of the containing memory word
module store_rmw_unit
   import store_rmw_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  store_type_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        resp_valid,
   output logic        resp_err
);
   state_t      state;
   logic [2:0]  sel_q, m_sel;
   logic [1:0]  k_q, m_k;
   logic [31:0] wdata_q, old_q, m_wdata, m_old, merged;
   logic        idle, err, rd;
   assign idle      = state == IDLE;
   assign req_ready = idle;
   // in IDLE the merger sees the live request so sw/swrr data is ready at accept
   assign m_sel   = idle ? store_type_sel : sel_q;
   assign m_k     = idle ? req_addr[1:0] : k_q;
   assign m_wdata = idle ? req_wdata : wdata_q;
   assign m_old   = state == READ ? mem_rdata : old_q;
   assign err = !(store_type_sel inside {ST_SW, ST_SB, ST_SH, ST_SWRR}) ||
                (store_type_sel == ST_SH && req_addr[0]) ||
                (store_type_sel == ST_SW && req_addr[1:0] != 2'b00);
   assign rd  = store_type_sel == ST_SB || store_type_sel == ST_SH;
   store_merge u_merge (
      .old_word (m_old),
      .wdata    (m_wdata),
      .sel      (m_sel),
      .k        (m_k),
      .merged   (merged)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sel_q      <= '0;
         k_q        <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               sel_q      <= store_type_sel;
               k_q        <= req_addr[1:0];
               wdata_q    <= req_wdata;
               mem_addr   <= {req_addr[31:2], 2'b00};
               mem_wdata  <= merged;
               mem_req    <= !err;
               mem_we     <= !err && !rd;
               resp_valid <= err;
               resp_err   <= err;
               state      <= err ? RESP : rd ? READ : WRITE;
            end
            READ: if (mem_ack) begin
               old_q     <= mem_rdata;
               mem_wdata <= merged;
               mem_we    <= 1'b1;
               state     <= WRITE;
            end
            WRITE: if (mem_ack) begin
               mem_req    <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: directed self-checking bench for store_rmw_unit
module tb_store_rmw_unit;
   logic        clk = 1'b0, reset_n = 1'b1, req_valid = 1'b0, mem_ack = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
   logic [2:0]  store_type_sel = '0;
   logic        req_ready, mem_req, mem_we, resp_valid, resp_err;
   logic [31:0] mem_addr, mem_wdata;
   int          vec = 0, bad = 0;
   int          rd_n, wr_n, resp_cyc, req_cycles;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic        addr_ok, wdata_ok, err_seen, rv_after, ready_after;

   store_rmw_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .store_type_sel (store_type_sel),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .resp_valid     (resp_valid),
      .resp_err       (resp_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // drives one request and plays memory with rw/ww wait cycles before each ack
   task automatic run_txn(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdw, input int rw, input int ww);
      int rc = 0, wc = 0;
      logic [31:0] a0 = '0, w0 = '0;
      logic have_a = 1'b0, have_w = 1'b0;
      rd_n = 0; wr_n = 0; resp_cyc = -1; req_cycles = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      addr_ok = 1'b1; wdata_ok = 1'b1; err_seen = 1'bx; rv_after = 1'bx; ready_after = 1'bx;
      req_valid = 1'b1; store_type_sel = sel; req_addr = addr; req_wdata = wd;
      tick;
      req_valid = 1'b0; store_type_sel = 3'b011; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
      for (int c = 1; c <= 50; c++) begin
         mem_rdata = 32'hBAD0_BAD0;
         if (mem_req) begin
            req_cycles++;
            if (!have_a) begin a0 = mem_addr; have_a = 1'b1; end
            else if (mem_addr !== a0) addr_ok = 1'b0;
            if (!mem_we) begin
               rd_addr = mem_addr;
               if (rc == rw) begin mem_ack = 1'b1; mem_rdata = rdw; rd_n++; end
               rc++;
            end else begin
               if (!have_w) begin w0 = mem_wdata; have_w = 1'b1; end
               else if (mem_wdata !== w0) wdata_ok = 1'b0;
               if (wc == ww) begin mem_ack = 1'b1; wr_n++; wr_addr = mem_addr; wr_data = mem_wdata; end
               wc++;
            end
         end
         if (resp_valid) begin
            resp_cyc = c;
            err_seen = resp_err;
            tick;
            mem_ack = 1'b0;
            rv_after = resp_valid;
            ready_after = req_ready;
            break;
         end
         tick;
         mem_ack = 1'b0;
      end
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      vec++;
      if ({req_ready, mem_req, mem_we, resp_valid, resp_err} !== 5'b10000) begin
         bad++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, mem_req, mem_we, resp_valid, resp_err});
      end
      vec++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         bad++; $display("FAIL reset_data got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
      end
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_sb;
      run_txn(3'b001, 32'h0000_1002, 32'h0000_00AB, 32'h1122_3344, 0, 0);
      vec++;
      if (rd_n !== 1 || rd_addr !== 32'h0000_1000) begin
         bad++; $display("FAIL sb_read got n=%0d addr=%h want 1/00001000", rd_n, rd_addr);
      end
      vec++;
      if (wr_n !== 1 || wr_addr !== 32'h0000_1000 || wr_data !== 32'h11AB_3344) begin
         bad++; $display("FAIL sb_write got n=%0d addr=%h data=%h want 1/00001000/11ab3344", wr_n, wr_addr, wr_data);
      end
      vec++;
      if (resp_cyc !== 3 || err_seen !== 1'b0) begin
         bad++; $display("FAIL sb_resp got cyc=%0d err=%b want 3/0", resp_cyc, err_seen);
      end
      vec++;
      if (rv_after !== 1'b0 || ready_after !== 1'b1) begin
         bad++; $display("FAIL sb_after got rv=%b ready=%b want 0/1", rv_after, ready_after);
      end
   endtask

   task automatic test_sh;
      run_txn(3'b010, 32'h0000_2002, 32'hFFFF_5566, 32'hDEAD_BEEF, 0, 0);
      vec++;
      if (wr_n !== 1 || wr_addr !== 32'h0000_2000 || wr_data !== 32'h5566_BEEF) begin
         bad++; $display("FAIL sh_write got n=%0d addr=%h data=%h want 1/00002000/5566beef", wr_n, wr_addr, wr_data);
      end
      vec++;
      if (rd_n !== 1 || resp_cyc !== 3 || err_seen !== 1'b0) begin
         bad++; $display("FAIL sh_resp got rd=%0d cyc=%0d err=%b want 1/3/0", rd_n, resp_cyc, err_seen);
      end
      run_txn(3'b010, 32'h0000_2001, 32'h0000_7788, 32'h0, 0, 0);
      vec++;
      if (resp_cyc !== 1 || err_seen !== 1'b1 || req_cycles !== 0) begin
         bad++; $display("FAIL sh_misaligned got cyc=%0d err=%b memreq=%0d want 1/1/0", resp_cyc, err_seen, req_cycles);
      end
   endtask

   task automatic test_swrr;
      run_txn(3'b100, 32'h0000_3001, 32'h1234_5678, 32'h0, 0, 0);
      vec++;
      if (rd_n !== 0 || wr_n !== 1 || wr_addr !== 32'h0000_3000 || wr_data !== 32'h3456_7812) begin
         bad++; $display("FAIL swrr_write got rd=%0d wr=%0d addr=%h data=%h want 0/1/00003000/34567812", rd_n, wr_n, wr_addr, wr_data);
      end
      vec++;
      if (resp_cyc !== 2 || err_seen !== 1'b0) begin
         bad++; $display("FAIL swrr_resp got cyc=%0d err=%b want 2/0", resp_cyc, err_seen);
      end
      run_txn(3'b100, 32'h0000_3003, 32'h1234_5678, 32'h0, 0, 0);
      vec++;
      if (wr_data !== 32'h7812_3456) begin
         bad++; $display("FAIL swrr_k3 got %h want 78123456", wr_data);
      end
   endtask

   task automatic test_wait_states;
      run_txn(3'b001, 32'h0000_1003, 32'h0000_00CD, 32'h1122_3344, 3, 2);
      vec++;
      if (wr_n !== 1 || wr_data !== 32'hCD22_3344 || wr_addr !== 32'h0000_1000) begin
         bad++; $display("FAIL wait_write got n=%0d addr=%h data=%h want 1/00001000/cd223344", wr_n, wr_addr, wr_data);
      end
      vec++;
      if (addr_ok !== 1'b1 || wdata_ok !== 1'b1) begin
         bad++; $display("FAIL wait_stable got addr_ok=%b wdata_ok=%b want 1/1", addr_ok, wdata_ok);
      end
      vec++;
      if (resp_cyc !== 8 || rv_after !== 1'b0 || req_cycles !== 7) begin
         bad++; $display("FAIL wait_resp got cyc=%0d after=%b reqcyc=%0d want 8/0/7", resp_cyc, rv_after, req_cycles);
      end
   endtask

   task automatic test_reset_mid_write;
      logic seen = 1'b0;
      req_valid = 1'b1; store_type_sel = 3'b000; req_addr = 32'h0000_4000; req_wdata = 32'h0102_0304;
      tick;
      req_valid = 1'b0;
      tick;
      tick;
      vec++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || req_ready !== 1'b0) begin
         bad++; $display("FAIL rst_pre got req=%b we=%b ready=%b want 1/1/0", mem_req, mem_we, req_ready);
      end
      #2 reset_n = 1'b0;
      #1;
      vec++;
      if ({mem_req, mem_we, resp_valid, req_ready} !== 4'b0001 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL rst_async got req/we/rv/ready=%b addr=%h want 0001/0", {mem_req, mem_we, resp_valid, req_ready}, mem_addr);
      end
      #3 reset_n = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (mem_req || resp_valid || !req_ready) seen = 1'b1;
      end
      mem_ack = 1'b0;
      vec++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL rst_late_ack got activity=%b want 0", seen);
      end
   endtask

   task automatic test_illegal;
      run_txn(3'b111, 32'h0000_5000, 32'h5555_5555, 32'h0, 0, 0);
      vec++;
      if (resp_cyc !== 1 || err_seen !== 1'b1 || req_cycles !== 0) begin
         bad++; $display("FAIL illegal got cyc=%0d err=%b memreq=%0d want 1/1/0", resp_cyc, err_seen, req_cycles);
      end
      run_txn(3'b000, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 0, 0);
      vec++;
      if (wr_n !== 1 || wr_addr !== 32'h0000_5000 || wr_data !== 32'hCAFE_F00D || rd_n !== 0) begin
         bad++; $display("FAIL sw_after_illegal got wr=%0d addr=%h data=%h rd=%0d want 1/00005000/cafef00d/0", wr_n, wr_addr, wr_data, rd_n);
      end
      vec++;
      if (resp_cyc !== 2 || err_seen !== 1'b0) begin
         bad++; $display("FAIL sw_resp got cyc=%0d err=%b want 2/0", resp_cyc, err_seen);
      end
      run_txn(3'b000, 32'h0000_5002, 32'hCAFE_F00D, 32'h0, 0, 0);
      vec++;
      if (resp_cyc !== 1 || err_seen !== 1'b1 || req_cycles !== 0) begin
         bad++; $display("FAIL sw_misaligned got cyc=%0d err=%b memreq=%0d want 1/1/0", resp_cyc, err_seen, req_cycles);
      end
   endtask

   initial begin
      test_reset;
      test_sb;
      test_sh;
      test_swrr;
      test_wait_states;
      test_reset_mid_write;
      test_illegal;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
